// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states, BCD constants, digit type and nine's-complement helper
package bcd_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, ADD = 3'd1, EAC = 3'd2, NEG = 3'd3, DONE = 3'd4} state_t;
  typedef logic [3:0] digit_t;
  localparam digit_t BCD_MAX = 4'd9;
  localparam digit_t BCD_ADJ = 4'd6;
  function automatic digit_t nines(input digit_t d);
    return BCD_MAX - d;
  endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: one-digit BCD adder (x, y, cin in; s, cout out) with +6 decimal correction
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] sum;
  assign sum  = {1'b0, x} + {1'b0, y} + {4'b0, cin};
  assign cout = sum > {1'b0, BCD_MAX};
  assign s    = cout ? sum[3:0] + BCD_ADJ : sum[3:0];
endmodule

// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial BCD add/subtract (clk, rst, start, mode, a, b in; busy, done, result, neg, ovf, err out)
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] result,
  output logic              neg,
  output logic              ovf,
  output logic              err
);
  localparam int W  = 4 * NDIG;
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  state_t         state, state_n;
  logic [IW-1:0]  idx;
  logic           cy, mode_r, neg_r, ovf_r, err_r, bad, last, co;
  logic [W-1:0]   a_r, b_r, acc, bx, acc_c;
  digit_t         sx, sy, s;
  always_comb begin
    bad   = 1'b0;
    bx    = '0;
    acc_c = '0;
    for (int i = 0; i < NDIG; i++) begin
      bad = bad | (a[4*i +: 4] > BCD_MAX) | (b[4*i +: 4] > BCD_MAX);
      bx[4*i +: 4]    = mode ? nines(b[4*i +: 4]) : b[4*i +: 4];
      acc_c[4*i +: 4] = nines(acc[4*i +: 4]);
    end
  end
  assign last = idx == IW'(NDIG - 1);
  // the end-around-carry pass reuses the digit adder with a zero addend
  assign sx = state == ADD ? a_r[4*idx +: 4] : acc[4*idx +: 4];
  assign sy = state == ADD ? b_r[4*idx +: 4] : 4'd0;
  bcd_digit_add u_add (.x(sx), .y(sy), .cin(cy), .s(s), .cout(co));
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (bad ? DONE : ADD) : IDLE;
      ADD:     state_n = last ? (!mode_r ? DONE : co ? EAC : NEG) : ADD;
      EAC:     state_n = last ? DONE : EAC;
      NEG:     state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      cy     <= 1'b0;
      mode_r <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      neg_r  <= 1'b0;
      ovf_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          err_r  <= bad;
          neg_r  <= 1'b0;
          ovf_r  <= 1'b0;
          acc    <= '0;
          idx    <= '0;
          cy     <= 1'b0;
          mode_r <= mode;
          a_r    <= a;
          b_r    <= bx;
        end
        ADD, EAC: begin
          acc[4*idx +: 4] <= s;
          cy  <= co;
          idx <= last ? '0 : IW'(idx + 1'b1);
          if (state == ADD && last && !mode_r) ovf_r <= co;
        end
        NEG: begin
          acc   <= acc_c;
          neg_r <= |acc_c;
        end
        default: ;
      endcase
    end
  end
  assign busy   = state != IDLE;
  assign done   = state == DONE;
  assign result = acc;
  assign neg    = neg_r;
  assign ovf    = ovf_r;
  assign err    = err_r;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb_bcd_serial_addsub: vector table, control corner cases and randomized checks against an arithmetic model
module tb_bcd_serial_addsub;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [11:0] a = '0, b = '0;
  logic        busy, done, neg, ovf, err;
  logic [11:0] result;
  int checks = 0, errors = 0;

  bcd_serial_addsub #(.NDIG(3)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .neg(neg), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          m;
    logic [11:0] va, vb, res;
    bit          n, o, e;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int dec(input logic [11:0] v);
    return v[11:8] * 100 + v[7:4] * 10 + v[3:0];
  endfunction

  function automatic logic [11:0] enc(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // latency counts clock edges after the start-sampling edge until done is seen
  task automatic model(input bit m, input logic [11:0] va, input logic [11:0] vb,
                       output logic [11:0] r, output bit n, output bit o, output bit e, output int lat);
    int x, y;
    e = 1'b0;
    for (int i = 0; i < 3; i++) e |= (va[4*i +: 4] > 9) || (vb[4*i +: 4] > 9);
    r = '0; n = 1'b0; o = 1'b0;
    x = dec(va); y = dec(vb);
    if (e) lat = 0;
    else if (!m) begin
      r = enc((x + y) % 1000); o = (x + y) > 999; lat = 3;
    end else if (x > y) begin
      r = enc(x - y); lat = 6;
    end else begin
      r = enc(y - x); n = y != x; lat = 4;
    end
  endtask

  task automatic run(input bit m, input logic [11:0] va, input logic [11:0] vb, input bit poke,
                     output logic [11:0] r, output bit n, output bit o, output bit e, output int lat);
    @(negedge clk);
    mode = m; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      if (poke && lat == 1) begin
        start = 1'b1; mode = 1'b0; a = 12'h999; b = 12'h999;
      end else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 1);
    r = result; n = neg; o = ovf; e = err;
    @(posedge clk); #1;
    chk("done_pulse_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("result_held", result, r);
  endtask

  task automatic check_op(input string tag, input vec_t v, input bit poke);
    logic [11:0] r;
    bit n, o, e;
    int lat;
    run(v.m, v.va, v.vb, poke, r, n, o, e, lat);
    chk({tag, "_result"}, r, v.res);
    chk({tag, "_neg"}, n, v.n);
    chk({tag, "_ovf"}, o, v.o);
    chk({tag, "_err"}, e, v.e);
    chk({tag, "_latency"}, lat, v.lat);
  endtask

  initial begin
    vec_t tbl[10];
    vec_t rv;
    int seen;
    tbl[0] = '{0, 12'h123, 12'h456, 12'h579, 0, 0, 0, 3};
    tbl[1] = '{0, 12'h999, 12'h001, 12'h000, 0, 1, 0, 3};
    tbl[2] = '{1, 12'h500, 12'h123, 12'h377, 0, 0, 0, 6};
    tbl[3] = '{1, 12'h123, 12'h500, 12'h377, 1, 0, 0, 4};
    tbl[4] = '{1, 12'h250, 12'h250, 12'h000, 0, 0, 0, 4};
    tbl[5] = '{0, 12'h1A3, 12'h000, 12'h000, 0, 0, 1, 0};
    tbl[6] = '{0, 12'h999, 12'h999, 12'h998, 0, 1, 0, 3};
    tbl[7] = '{1, 12'h000, 12'h999, 12'h999, 1, 0, 0, 4};
    tbl[8] = '{1, 12'h999, 12'h000, 12'h999, 0, 0, 0, 6};
    tbl[9] = '{1, 12'h012, 12'h00F, 12'h000, 0, 0, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result, 0);
    chk("reset_flags", {busy, done, neg, ovf, err}, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 10; i++) check_op($sformatf("vec%0d", i), tbl[i], 1'b0);

    check_op("busy_start_ignored", tbl[2], 1'b1);

    // reset in the middle of the ADD pass
    @(negedge clk);
    mode = 1'b0; a = 12'h123; b = 12'h456; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("busy_mid_add", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_result", result, 0);
    chk("midrst_flags", {busy, done, neg, ovf, err}, 0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("midrst_no_done", seen, 0);

    for (int k = 0; k < 150; k++) begin
      rv.m = 1'($urandom_range(0, 1));
      rv.va = enc($urandom_range(0, 999));
      rv.vb = enc($urandom_range(0, 999));
      if ($urandom_range(0, 15) == 0) rv.va[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 15) == 0) rv.vb[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 9) == 0) rv.vb = rv.va;
      model(rv.m, rv.va, rv.vb, rv.res, rv.n, rv.o, rv.e, rv.lat);
      check_op($sformatf("rnd%0d", k), rv, 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
